fft_twiddle_seq: RTL
====================

Name: fft_twiddle_seq

Overview:
- Twiddle sequencer for the radix-2 DIF FFT datapath. Drives the non-data operands of the 16x10 twiddle complex multiplier: w_r, w_i and the 27-bit rounding constant.
- For a commanded stage it streams N/2 twiddles in butterfly order, optionally conjugated for the inverse transform, under a valid/ready handshake.
- Coefficients come from an internal quarter-wave cosine table.

Parameters:
- LOG2N, 6, log2 of FFT size N (N=64 default); legal 3..10.
- TW_W, 10, signed twiddle width; +1.0 = 256.
- RND, 512, rounding constant driven on trun_mu_16 (half LSB of product bit 10).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a stage sequence; sampled only in IDLE.
- stage  in  4  stage index s, 0..LOG2N-1; latched on start.
- inverse  in  1  1 = conjugate twiddles (IFFT); latched on start.
- tw_ready  in  1  downstream accepts the current twiddle.
- tw_valid  out  1  w_r/w_i/tw_idx/tw_last hold a valid twiddle.
- w_r  out  TW_W  signed real part.
- w_i  out  TW_W  signed imaginary part.
- tw_idx  out  LOG2N-1  butterfly index j of the current twiddle.
- tw_last  out  1  current twiddle is j = N/2-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last twiddle is accepted.
- trun_mu_16  out  27  constant RND, independent of reset and state.

Behaviour:
- Reset values: tw_valid=0, w_r=0, w_i=0, tw_idx=0, tw_last=0, busy=0, done=0; FSM=IDLE; j counter=0; latched stage/inverse=0.
- Reset mid-sequence aborts immediately; no done pulse is generated.
- States:
  - IDLE: on start, latch s and inverse, set j=0, go to RUN. If stage >= LOG2N, clamp s to LOG2N-1.
  - RUN: produce twiddles j = 0..N/2-1. After the handshake on j = N/2-1, go to IDLE and pulse done in the following cycle.
- start is ignored while in RUN.
- Exponent: H = N >> (s+1); e = (j mod H) << s; 0 <= e < N/2.
- Table: C[i] = round(256*cos(2*pi*i/N)) for i = 0..N/4 (round half away from zero). Combinational case/function; no RAM.
- If e <= N/4: cosv = C[e], sinv = C[N/4-e].
- Else, with e' = e - N/4: cosv = -C[N/4-e'], sinv = C[e'].
- Forward: w_r = cosv, w_i = -sinv. Inverse: w_r = cosv, w_i = +sinv. Values lie in -256..256.
- Output register is a single stage. It loads the next twiddle when (!tw_valid || tw_ready) and j has not been exhausted.
- First tw_valid is asserted 1 cycle after start is sampled; throughput is 1 twiddle per clock with tw_ready held high.
- tw_ready low: all outputs hold stable and j does not advance.
- tw_valid must never drop without a handshake.
- tw_ready is ignored when tw_valid=0.
- tw_valid falls in the cycle after the last handshake, unless the register is reloaded; it is never reloaded past the last twiddle.
- done pulses exactly once per completed sequence. A start that is high in the same cycle as done is sampled in IDLE and begins a new sequence.

Test Plan:
- N=64, stage=0, forward, tw_ready=1:
  - j=0 -> (256,0); j=8 -> (181,-181); j=16 -> (0,-256); j=24 -> (-181,-181).
  - tw_last and the handshake on j=31, done 1 cycle later; exactly 32 handshakes.
- stage=1, forward: j=20 -> e=8 -> (181,-181); j=16 -> e=0 -> (256,0).
- stage=0, inverse: j=8 -> (181,+181); j=24 -> (-181,+181).
- stage=5 (last stage): all 32 outputs are (256,0).
- Backpressure, stage=0:
  - tw_ready toggles pseudo-randomly; outputs stay stable while stalled; sequence and count match the unstalled run.
  - start pulses during RUN are ignored.
- Reset and constant checks:
  - Assert rst at j=10: next cycle tw_valid=0, busy=0, no done pulse.
  - A new start then restarts from j=0.
  - trun_mu_16 = 512 throughout.

Source files
------------

// File: rtl/fft_twiddle_seq.sv
// Twiddle sequencer for a radix-2 DIF FFT: streams the N/2 twiddles of one stage
// over a valid/ready handshake, optionally conjugated for the inverse transform.
module fft_twiddle_seq #(
  parameter int LOG2N = 6,
  parameter int TW_W  = 10,
  parameter int RND   = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        stage,
  input  logic              inverse,
  input  logic              tw_ready,
  output logic              tw_valid,
  output logic [TW_W-1:0]   w_r,
  output logic [TW_W-1:0]   w_i,
  output logic [LOG2N-2:0]  tw_idx,
  output logic              tw_last,
  output logic              busy,
  output logic              done,
  output logic [26:0]       trun_mu_16
);

  localparam int  N  = 1 << LOG2N;
  localparam int  QN = N / 4;
  localparam int  JW = LOG2N - 1;
  localparam int  CW = LOG2N;
  localparam real PI = 3.141592653589793;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic              inv_q, inv_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [TW_W-1:0]   w_r_q, w_r_d;
  logic [TW_W-1:0]   w_i_q, w_i_d;
  logic [JW-1:0]     idx_q, idx_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  // Quarter-wave cosine table, values are non-negative so +0.5 then truncate rounds half away from zero
  logic [TW_W-1:0] cos_tab [0:QN];
  for (genvar gi = 0; gi <= QN; gi++) begin : g_cos
    localparam int CV = $rtoi(256.0 * $cos(2.0 * PI * gi / N) + 0.5);
    assign cos_tab[gi] = TW_W'(CV);
  end

  logic [JW-1:0]   j_w, mask_w, e_w, ep_w;
  logic [TW_W-1:0] cosv, sinv;

  always_comb begin
    j_w    = cnt_q[JW-1:0];
    mask_w = {JW{1'b1}} >> s_q;
    e_w    = (j_w & mask_w) << s_q;
    ep_w   = e_w - JW'(QN);
    if (e_w <= JW'(QN)) begin
      cosv = cos_tab[e_w];
      sinv = cos_tab[JW'(QN) - e_w];
    end else begin
      cosv = TW_W'(0) - cos_tab[JW'(QN) - ep_w];
      sinv = cos_tab[ep_w];
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    w_r_d   = w_r_q;
    w_i_d   = w_i_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = (stage >= 4'(LOG2N)) ? 4'(LOG2N - 1) : stage;
          inv_d   = inverse;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (valid_q && tw_ready && last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (!valid_q || tw_ready) begin
          // Register is free: load the next twiddle unless all N/2 have been issued
          if (cnt_q < CW'(N / 2)) begin
            valid_d = 1'b1;
            w_r_d   = cosv;
            w_i_d   = inv_q ? sinv : (TW_W'(0) - sinv);
            idx_d   = j_w;
            last_d  = (j_w == {JW{1'b1}});
            cnt_d   = cnt_q + 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      w_r_q   <= '0;
      w_i_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      w_r_q   <= w_r_d;
      w_i_q   <= w_i_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign tw_valid   = valid_q;
  assign w_r        = w_r_q;
  assign w_i        = w_i_q;
  assign tw_idx     = idx_q;
  assign tw_last    = last_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign trun_mu_16 = 27'(RND);

endmodule
